clashup_loader: RTL and testbench

Program loader for the Clashup CPU: receives a framed bytecode image over a valid/ready byte stream and writes it into the CPU's 256-byte program RAM. It also holds the CPU in reset until a complete, checksum-verified image has landed. It sits between the host link (UART/SPI front end) and the CPU/RAM pair, replacing load-at-elaboration of program images.

---
 rtl/clashup_pkg.sv | 11 +
 rtl/clashup_loader_if.sv | 11 +
 rtl/clashup_loader.sv | 102 ++++++++++
 tb/tb_clashup_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clashup_pkg.sv
// clashup_pkg: constants and types shared by the Clashup loader, CPU and their benches
package clashup_pkg;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DEPTH = 1 << RAM_ADDR_W;
  localparam int RAM_DATA_W = 8;
  localparam logic [7:0] OP_SET = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_OUT = 8'h03;
  typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_DATA, ST_CHK, ST_EVAL} loader_state_e;
endpackage

// File: rtl/clashup_loader_if.sv
// clashup_loader_if: byte-stream input and program-RAM write port of the loader
interface clashup_loader_if #(parameter int ADDR_W = 8);
  logic s_valid;
  logic [7:0] s_data;
  logic s_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata;
  modport master (output s_valid, s_data, input s_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input s_valid, s_data, output s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/clashup_loader.sv
// clashup_loader: loads a framed, checksummed image into program RAM and holds the CPU in reset until it verifies
module clashup_loader
  import clashup_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic clk,
  input  logic rst_n,
  clashup_loader_if.slave bus,
  output logic cpu_rst,
  output logic done,
  output logic err
);
  localparam int CW = ADDR_W + 1;
  loader_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [7:0] sum_q, sum_d, mem_wdata_q, mem_wdata_d;
  logic mem_we_q, mem_we_d, cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic s_ready, acc;
  assign s_ready = state_q != ST_EVAL;
  assign acc = bus.s_valid && s_ready;
  assign bus.s_ready = s_ready;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst = cpu_rst_q;
  assign done = done_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    sum_d = sum_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d = done_q;
    err_d = err_q;
    case (state_q)
      ST_HUNT: if (acc && bus.s_data == SYNC_BYTE) begin
        state_d = ST_LEN;
        cpu_rst_d = 1'b1;
        done_d = 1'b0;
        err_d = 1'b0;
      end
      ST_LEN: if (acc) begin
        state_d = ST_DATA;
        // LEN=0 encodes a full 2^ADDR_W-byte image
        cnt_d = (bus.s_data == 8'd0) ? CW'(1) << ADDR_W : CW'(bus.s_data);
        sum_d = bus.s_data;
        addr_d = '0;
      end
      ST_DATA: if (acc) begin
        mem_we_d = 1'b1;
        mem_addr_d = addr_q;
        mem_wdata_d = bus.s_data;
        sum_d = sum_q + bus.s_data;
        addr_d = addr_q + ADDR_W'(1);
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ST_CHK : ST_DATA;
      end
      ST_CHK: if (acc) begin
        sum_d = sum_q + bus.s_data;
        state_d = ST_EVAL;
      end
      default: begin
        state_d = ST_HUNT;
        done_d = sum_q == 8'd0;
        err_d = sum_q != 8'd0;
        cpu_rst_d = sum_q != 8'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      cnt_q <= '0;
      addr_q <= '0;
      sum_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      sum_q <= sum_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_clashup_loader.sv
// tb_clashup_loader: directed frames with hand-computed checksums and expected RAM writes
module tb_clashup_loader;
  import clashup_pkg::*;
  localparam logic [20:0] RST_VEC = {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rst, done, err;
  int checks = 0;
  int errors = 0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] pl[$];
  clashup_loader_if #(.ADDR_W(8)) bus();
  clashup_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cpu_rst(cpu_rst), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.mem_we === 1'b1) begin
    wa.push_back(bus.mem_addr);
    wd.push_back(bus.mem_wdata);
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data = b;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: s_ready=%b required 1", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask
  task automatic send_body(input logic [7:0] len, input logic [7:0] chk, input bit gap);
    send_byte(len);
    if (gap) @(negedge clk);
    foreach (pl[i]) begin
      send_byte(pl[i]);
      if (gap) @(negedge clk);
    end
    send_byte(chk);
  endtask
  task automatic test_reset;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h required %h", {bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err}, RST_VEC);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err} !== RST_VEC) begin
      errors++;
      $display("FAIL idle_after_reset: got %h required %h", {bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err}, RST_VEC);
    end
  endtask
  task automatic test_valid_frame;
    int n;
    wa.delete(); wd.delete();
    pl = {8'h01, 8'h00, 8'h05};
    send_byte(8'hA5);
    send_body(8'h03, 8'hF7, 1'b0);
    checks++;
    if ({bus.s_ready, done, cpu_rst} !== 3'b001) begin
      errors++;
      $display("FAIL valid_eval_cycle: ready/done/cpu_rst=%b required 001", {bus.s_ready, done, cpu_rst});
    end
    @(negedge clk);
    checks++;
    if ({done, cpu_rst, err} !== 3'b100) begin
      errors++;
      $display("FAIL valid_status: done/cpu_rst/err=%b required 100", {done, cpu_rst, err});
    end
    n = 0;
    foreach (pl[i]) if (i >= wa.size() || wa[i] !== 8'(i) || wd[i] !== pl[i]) n++;
    checks++;
    if (n != 0 || wa.size() != pl.size()) begin
      errors++;
      $display("FAIL valid_writes: %0d writes with %0d wrong, required %0d exact", wa.size(), n, pl.size());
    end
  endtask
  task automatic test_bad_checksum;
    int n;
    wa.delete(); wd.delete();
    pl = {8'h01, 8'h00, 8'h05};
    send_byte(8'hA5);
    send_body(8'h03, 8'hF6, 1'b0);
    checks++;
    if ({bus.s_ready, err, done} !== 3'b000) begin
      errors++;
      $display("FAIL bad_eval_cycle: ready/err/done=%b required 000", {bus.s_ready, err, done});
    end
    @(negedge clk);
    checks++;
    if ({done, cpu_rst, err} !== 3'b011) begin
      errors++;
      $display("FAIL bad_status: done/cpu_rst/err=%b required 011", {done, cpu_rst, err});
    end
    n = 0;
    foreach (pl[i]) if (i >= wa.size() || wa[i] !== 8'(i) || wd[i] !== pl[i]) n++;
    checks++;
    if (n != 0 || wa.size() != pl.size()) begin
      errors++;
      $display("FAIL bad_writes: %0d writes with %0d wrong, required %0d exact", wa.size(), n, pl.size());
    end
  endtask
  task automatic test_garbage;
    int n;
    wa.delete(); wd.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    @(negedge clk);
    checks++;
    if (wa.size() != 0 || {err, cpu_rst, bus.s_ready} !== 3'b111) begin
      errors++;
      $display("FAIL garbage_ignored: %0d writes err/cpu_rst/ready=%b, required 0 writes 111", wa.size(), {err, cpu_rst, bus.s_ready});
    end
    pl = {8'h3C, 8'hC3};
    send_byte(8'hA5);
    send_body(8'h02, 8'hFF, 1'b0);
    @(negedge clk);
    checks++;
    if ({done, cpu_rst, err} !== 3'b100) begin
      errors++;
      $display("FAIL garbage_status: done/cpu_rst/err=%b required 100", {done, cpu_rst, err});
    end
    n = 0;
    foreach (pl[i]) if (i >= wa.size() || wa[i] !== 8'(i) || wd[i] !== pl[i]) n++;
    checks++;
    if (n != 0 || wa.size() != pl.size()) begin
      errors++;
      $display("FAIL garbage_writes: %0d writes with %0d wrong, required %0d exact", wa.size(), n, pl.size());
    end
  endtask
  task automatic test_full_image;
    int n;
    wa.delete(); wd.delete();
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    send_byte(8'hA5);
    send_body(8'h00, 8'h80, 1'b0);
    checks++;
    if ({bus.s_ready, done} !== 2'b00) begin
      errors++;
      $display("FAIL full_eval_cycle: ready/done=%b required 00", {bus.s_ready, done});
    end
    @(negedge clk);
    checks++;
    if ({done, cpu_rst, err} !== 3'b100) begin
      errors++;
      $display("FAIL full_status: done/cpu_rst/err=%b required 100", {done, cpu_rst, err});
    end
    repeat (3) @(negedge clk);
    n = 0;
    foreach (pl[i]) if (i >= wa.size() || wa[i] !== 8'(i) || wd[i] !== pl[i]) n++;
    checks++;
    if (n != 0 || wa.size() != 256) begin
      errors++;
      $display("FAIL full_writes: %0d writes with %0d wrong, required 256 exact", wa.size(), n);
    end
  endtask
  task automatic test_reset_mid_frame;
    int n;
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h01, 8'h22}) begin
      errors++;
      $display("FAIL mid_frame_write: we/addr/data=%h required 10122", {bus.mem_we, bus.mem_addr, bus.mem_wdata});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err} !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h required %h", {bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err}, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wa.delete(); wd.delete();
    pl = {8'hAA, 8'hBB};
    send_byte(8'hA5);
    send_body(8'h02, 8'h99, 1'b0);
    @(negedge clk);
    checks++;
    if ({done, cpu_rst, err} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_status: done/cpu_rst/err=%b required 100", {done, cpu_rst, err});
    end
    n = 0;
    foreach (pl[i]) if (i >= wa.size() || wa[i] !== 8'(i) || wd[i] !== pl[i]) n++;
    checks++;
    if (n != 0 || wa.size() != pl.size()) begin
      errors++;
      $display("FAIL post_reset_writes: %0d writes with %0d wrong, required %0d exact", wa.size(), n, pl.size());
    end
  endtask
  task automatic test_reload_throttled;
    int n;
    wa.delete(); wd.delete();
    send_byte(8'hA5);
    checks++;
    if ({done, cpu_rst, bus.mem_we} !== 3'b010) begin
      errors++;
      $display("FAIL reload_sync: done/cpu_rst/mem_we=%b required 010", {done, cpu_rst, bus.mem_we});
    end
    @(negedge clk);
    pl = {OP_SET, OP_ADD, OP_OUT};
    send_body(8'h03, 8'hF7, 1'b1);
    checks++;
    if ({bus.s_ready, done, cpu_rst} !== 3'b001) begin
      errors++;
      $display("FAIL reload_eval_cycle: ready/done/cpu_rst=%b required 001", {bus.s_ready, done, cpu_rst});
    end
    @(negedge clk);
    checks++;
    if ({done, cpu_rst, err} !== 3'b100) begin
      errors++;
      $display("FAIL reload_status: done/cpu_rst/err=%b required 100", {done, cpu_rst, err});
    end
    n = 0;
    foreach (pl[i]) if (i >= wa.size() || wa[i] !== 8'(i) || wd[i] !== pl[i]) n++;
    checks++;
    if (n != 0 || wa.size() != pl.size()) begin
      errors++;
      $display("FAIL reload_writes: %0d writes with %0d wrong, required %0d exact", wa.size(), n, pl.size());
    end
  endtask
  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_garbage();
    test_full_image();
    test_reset_mid_frame();
    test_reload_throttled();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
